laser_link_scheduler: RTL and testbench
=======================================

// Module: laser_link_scheduler
// PURPOSE
//  Shares the single laser UART link (byte TX/RX cores) between NREQ requesters (init sequencer,
//  off sequencer, status poller, host bridge). Round-robin arbitration per 32-bit command word;
//  sends the word MSB byte first, optionally collects a 4-byte reply with timeout, and returns
//  the reply to the granted requester. Sits between the laser control FSMs and the UART cores.
// PARAMETERS
//  NREQ         4         number of requesters (2..8)
//  TIMEOUT_CYC  16777216  max clk cycles between reply bytes (and from RECV entry to first byte)
//  GAP_CYC      1024      idle guard cycles after each transaction before the next grant
// PORTS
//  clk          in   1        system clock
//  pll_rst      in   1        asynchronous, active-high reset
//  req          in   NREQ     per-requester request level; held until own done pulse
//  cmd_word     in   32*NREQ  command word of requester i at [32*i+31:32*i]
//  expect_resp  in   NREQ     1 = laser replies with 4 bytes to this command
//  grant        out  NREQ     one-hot, high for whole transaction of the served requester
//  done         out  NREQ     one-cycle pulse to served requester at transaction end
//  resp_word    out  32       reply word; valid in done cycle, held until next done
//  resp_err     out  1        1 = reply timed out; valid with done, held until next done
//  tx_start     out  1        one-cycle strobe to UART TX
//  tx_byte      out  8        byte to UART TX, stable from tx_start until tx_done
//  tx_done      in   1        UART TX byte finished (one-cycle pulse)
//  rx_dv        in   1        UART RX byte valid (one-cycle pulse)
//  rx_byte      in   8        received byte, valid with rx_dv
//  link_busy    out  1        1 in every state except IDLE
//  link_ok      out  1        0 after reset; 1 after a reply received, 0 after a timeout
// BEHAVIOUR
//  - Reset (any state): all outputs 0, FSM -> IDLE, RR pointer -> 0, counters cleared.
//  - FSM: IDLE -> SEND -> SEND_WAIT -> (SEND | RECV | DONE); RECV -> DONE; DONE -> GAP -> IDLE.
//  - IDLE: if any req, pick first requester at/after RR pointer (wrap NREQ-1 -> 0); next cycle
//    grant[i]=1, cmd_word[i] and expect_resp[i] latched into shift reg; pointer <= i+1 mod NREQ.
//    Grant latency: 1 cycle from req sampled high in IDLE.
//  - SEND: tx_start=1 for 1 cycle, tx_byte = shift[31:24]; byte count +1 -> SEND_WAIT.
//  - SEND_WAIT: on tx_done shift <<= 8; count<4 -> SEND; count==4 -> RECV if expect_resp else DONE.
//    Byte order on wire: cmd[31:24], [23:16], [15:8], [7:0].
//  - RECV: timer cleared on entry and on each rx_dv; rx_dv shifts resp = {resp[23:0], rx_byte};
//    4th byte -> DONE with err=0. Timer reaching TIMEOUT_CYC-1 -> DONE with err=1, resp_word=0.
//    rx_dv and timer expiry same cycle: byte wins (timer cleared).
//  - DONE: one cycle; done[i]=1, resp_word/resp_err/link_ok updated; no-reply commands give
//    resp_word=0, resp_err=0, link_ok unchanged. grant drops the following cycle.
//  - GAP: GAP_CYC cycles, then IDLE. GAP_CYC=0 -> straight to IDLE.
//  - rx_dv outside RECV ignored (stale bytes discarded). tx_done outside SEND_WAIT ignored.
//  - req[i] dropped mid-transaction: transaction still completes, done[i] still pulses.
//  - Arbitration only in IDLE; requests arriving mid-transaction wait; no starvation (RR).
//  - Counters: byte count 3 bits, timer $clog2(TIMEOUT_CYC) bits, gap $clog2(GAP_CYC+1) bits.
// STRUCTURE
//  - Package laser_link_pkg: FSM state encoding, BYTES_PER_WORD=4, default TIMEOUT/GAP constants.
//  - Sub-module laser_rr_arbiter: combinational one-hot pick from req + pointer, parameter NREQ.
//  - Top holds FSM, shift registers, timer, gap counter, output registers.
// TESTING (bench uses TIMEOUT_CYC=64, GAP_CYC=8, UART cores modelled by tx_done/rx_dv drivers)
//  - req=4'b0001, cmd0=32'hA5C3_0F12, expect=0 -> tx bytes A5,C3,0F,12; done[0], err=0, 8 gap cycles.
//  - req=4'b0010, cmd1=32'h0400_0001, expect=1, rx 12,34,56,78 -> done[1], resp=32'h12345678, link_ok=1.
//  - req=4'b1111 held, no reply needed -> grants in order 0,1,2,3,0; each grant one-hot.
//  - expect=1, no rx bytes -> done at 64 cycles after RECV entry, resp_err=1, resp=0, link_ok=0.
//  - expect=1, 2 bytes then silence; rx_dv during GAP -> err=1; stray byte not in next reply.
//  - pll_rst asserted in SEND_WAIT after 2 bytes -> all outputs 0 next cycle; fresh req resends byte 0.

Source files
------------

// File: rtl/laser_link_pkg.sv
// ---------------------------------------------------------------------------
// laser_link_pkg
//   Shared definitions for the laser UART link scheduler:
//   - state_t          : scheduler FSM state encoding
//   - BYTES_PER_WORD   : bytes per command / reply word on the wire
//   - DEF_TIMEOUT_CYC  : default reply timeout in clk cycles
//   - DEF_GAP_CYC      : default idle guard after each transaction
// ---------------------------------------------------------------------------
package laser_link_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SEND      = 3'd1,
      ST_SEND_WAIT = 3'd2,
      ST_RECV      = 3'd3,
      ST_DONE      = 3'd4,
      ST_GAP       = 3'd5
   } state_t;

   localparam int BYTES_PER_WORD  = 4;
   localparam int DEF_TIMEOUT_CYC = 16777216;
   localparam int DEF_GAP_CYC     = 1024;

endpackage : laser_link_pkg

// File: rtl/laser_rr_arbiter.sv
// ---------------------------------------------------------------------------
// laser_rr_arbiter
//   Combinational round-robin pick: the first requester at or after ptr,
//   wrapping from NREQ-1 back to 0.
// Ports
//   req       in   NREQ    request levels
//   ptr       in   IDX_W   index searched first
//   pick      out  NREQ    one-hot winner (all zero when no request)
//   pick_idx  out  IDX_W   index of the winner
//   pick_any  out  1       at least one request present
// ---------------------------------------------------------------------------
module laser_rr_arbiter #(
   parameter  int NREQ  = 4,
   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic [NREQ-1:0]  pick,
   output logic [IDX_W-1:0] pick_idx,
   output logic             pick_any
);

   int               idx_i;
   logic [IDX_W-1:0] idx;

   always_comb begin
      // NOTE: every variable gets a default before any conditional logic,
      // so no path leaves one unassigned and no latch is inferred.
      pick     = '0;
      pick_idx = '0;
      pick_any = 1'b0;
      idx_i    = 0;
      idx      = '0;
      for (int k = 0; k < NREQ; k++) begin
         // Explicit wrap: NREQ need not be a power of two.
         idx_i = int'(ptr) + k;
         if (idx_i >= NREQ) idx_i = idx_i - NREQ;
         idx = IDX_W'(idx_i);
         if (!pick_any && req[idx]) begin
            pick_any  = 1'b1;
            pick[idx] = 1'b1;
            pick_idx  = idx;
         end
      end
   end

endmodule : laser_rr_arbiter

// File: rtl/laser_link_scheduler.sv
// ---------------------------------------------------------------------------
// laser_link_scheduler
//   Shares one laser UART link between NREQ requesters. Round-robin grant per
//   32-bit command word, sends it MSB byte first, optionally collects a 4-byte
//   reply under a per-byte timeout, returns the reply to the served requester
//   and then holds the link idle for GAP_CYC guard cycles.
// Ports
//   clk, pll_rst      clock; asynchronous active-high reset
//   req[NREQ]         request levels, held until own done pulse
//   cmd_word          command word of requester i at [32*i+31:32*i]
//   expect_resp       1 = this command is answered with 4 bytes
//   grant[NREQ]       one-hot, high for the whole transaction
//   done[NREQ]        one-cycle pulse to the served requester
//   resp_word/err     reply word and timeout flag, held until next done
//   tx_start/tx_byte  byte strobe and data to the UART TX core
//   tx_done           UART TX byte finished
//   rx_dv/rx_byte     UART RX byte strobe and data
//   link_busy         1 whenever the scheduler is not idle
//   link_ok           1 after a good reply, 0 after reset or a timeout
// ---------------------------------------------------------------------------
module laser_link_scheduler
   import laser_link_pkg::*;
#(
   parameter int NREQ        = 4,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter int GAP_CYC     = DEF_GAP_CYC
) (
   input  logic                clk,
   input  logic                pll_rst,
   input  logic [NREQ-1:0]     req,
   input  logic [32*NREQ-1:0]  cmd_word,
   input  logic [NREQ-1:0]     expect_resp,
   output logic [NREQ-1:0]     grant,
   output logic [NREQ-1:0]     done,
   output logic [31:0]         resp_word,
   output logic                resp_err,
   output logic                tx_start,
   output logic [7:0]          tx_byte,
   input  logic                tx_done,
   input  logic                rx_dv,
   input  logic [7:0]          rx_byte,
   output logic                link_busy,
   output logic                link_ok
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int GAP_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

   localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [GAP_W-1:0] GAP_LAST  = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;
   localparam logic [2:0]       CNT_WORD  = 3'(BYTES_PER_WORD);
   localparam logic [2:0]       CNT_LAST  = 3'(BYTES_PER_WORD - 1);

   state_t           state, state_nxt;
   logic [IDX_W-1:0] rr_ptr;
   logic [NREQ-1:0]  pick;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_any;
   logic [31:0]      cmd_sel;
   logic             expect_sel;

   // One register serves both directions: command bytes shift out of the
   // top, reply bytes shift in at the bottom once the command has drained.
   logic [31:0]      shift_q;
   logic             expect_q;
   logic [2:0]       byte_cnt;
   logic [TMR_W-1:0] timer;
   logic [GAP_W-1:0] gap_cnt;

   logic             rx_last;
   logic             timed_out;

   laser_rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req      (req),
      .ptr      (rr_ptr),
      .pick     (pick),
      .pick_idx (pick_idx),
      .pick_any (pick_any)
   );

   // One-hot select of the winner's command word and reply flag.
   always_comb begin
      cmd_sel    = '0;
      expect_sel = |(expect_resp & pick);
      for (int i = 0; i < NREQ; i++) begin
         if (pick[i]) cmd_sel = cmd_sel | cmd_word[32*i +: 32];
      end
   end

   // A byte arriving on the expiry cycle wins: rx_dv is tested first.
   assign rx_last   = (state == ST_RECV) && rx_dv && (byte_cnt == CNT_LAST);
   assign timed_out = (state == ST_RECV) && !rx_dv && (timer == TMR_LAST);

   // State register.
   always_ff @(posedge clk or posedge pll_rst) begin
      if (pll_rst) begin
         state <= ST_IDLE;
      end else begin
         // NOTE: clocked state uses non-blocking assignments so every flop
         // samples pre-edge values regardless of statement order.
         state <= state_nxt;
      end
   end

   // Next state and combinational outputs.
   always_comb begin
      state_nxt = state;
      tx_start  = 1'b0;
      link_busy = (state != ST_IDLE);
      done      = '0;
      unique case (state)
         ST_IDLE: begin
            if (pick_any) state_nxt = ST_SEND;
         end
         ST_SEND: begin
            tx_start  = 1'b1;
            state_nxt = ST_SEND_WAIT;
         end
         ST_SEND_WAIT: begin
            if (tx_done) begin
               if (byte_cnt < CNT_WORD) state_nxt = ST_SEND;
               else if (expect_q)       state_nxt = ST_RECV;
               else                     state_nxt = ST_DONE;
            end
         end
         ST_RECV: begin
            if (rx_last || timed_out) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done      = grant;
            state_nxt = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
         end
         ST_GAP: begin
            if (gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign tx_byte = shift_q[31:24];

   // Datapath: grant, shift register, counters and reply outputs.
   always_ff @(posedge clk or posedge pll_rst) begin
      if (pll_rst) begin
         grant     <= '0;
         rr_ptr    <= '0;
         shift_q   <= '0;
         expect_q  <= 1'b0;
         byte_cnt  <= '0;
         timer     <= '0;
         gap_cnt   <= '0;
         resp_word <= '0;
         resp_err  <= 1'b0;
         link_ok   <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (pick_any) begin
                  grant    <= pick;
                  shift_q  <= cmd_sel;
                  expect_q <= expect_sel;
                  byte_cnt <= '0;
                  rr_ptr   <= (pick_idx == IDX_W'(NREQ - 1)) ? '0 : pick_idx + IDX_W'(1);
               end
            end
            ST_SEND: begin
               byte_cnt <= byte_cnt + 3'd1;
            end
            ST_SEND_WAIT: begin
               if (tx_done) begin
                  shift_q <= {shift_q[23:0], 8'h00};
                  if (byte_cnt == CNT_WORD) begin
                     byte_cnt <= '0;
                     timer    <= '0;
                     if (!expect_q) begin
                        resp_word <= '0;
                        resp_err  <= 1'b0;
                     end
                  end
               end
            end
            ST_RECV: begin
               if (rx_dv) begin
                  shift_q  <= {shift_q[23:0], rx_byte};
                  byte_cnt <= byte_cnt + 3'd1;
                  timer    <= '0;
                  if (rx_last) begin
                     resp_word <= {shift_q[23:0], rx_byte};
                     resp_err  <= 1'b0;
                     link_ok   <= 1'b1;
                  end
               end else if (timed_out) begin
                  resp_word <= '0;
                  resp_err  <= 1'b1;
                  link_ok   <= 1'b0;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            ST_DONE: begin
               grant   <= '0;
               gap_cnt <= '0;
            end
            ST_GAP: begin
               gap_cnt <= gap_cnt + GAP_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule : laser_link_scheduler

// File: tb/tb_laser_link_scheduler.sv
// ---------------------------------------------------------------------------
// tb_laser_link_scheduler
//   Drives the scheduler with directed and $urandom transactions and compares
//   each against a transaction-level model: round-robin winner, wire bytes,
//   reply word/error/link_ok, timeout latency and guard-gap length.
//   A UART TX stand-in answers tx_start with a delayed tx_done pulse.
// ---------------------------------------------------------------------------
module tb_laser_link_scheduler;

   localparam int NREQ = 4;
   localparam int TO   = 64;
   localparam int GAP  = 8;

   logic                clk = 1'b0;
   logic                pll_rst = 1'b1;
   logic [NREQ-1:0]     req = '0;
   logic [32*NREQ-1:0]  cmd_word = '0;
   logic [NREQ-1:0]     expect_resp = '0;
   logic [NREQ-1:0]     grant;
   logic [NREQ-1:0]     done;
   logic [31:0]         resp_word;
   logic                resp_err;
   logic                tx_start;
   logic [7:0]          tx_byte;
   logic                tx_done = 1'b0;
   logic                rx_dv = 1'b0;
   logic [7:0]          rx_byte = '0;
   logic                link_busy;
   logic                link_ok;

   laser_link_scheduler #(.NREQ(NREQ), .TIMEOUT_CYC(TO), .GAP_CYC(GAP)) dut (
      .clk         (clk),
      .pll_rst     (pll_rst),
      .req         (req),
      .cmd_word    (cmd_word),
      .expect_resp (expect_resp),
      .grant       (grant),
      .done        (done),
      .resp_word   (resp_word),
      .resp_err    (resp_err),
      .tx_start    (tx_start),
      .tx_byte     (tx_byte),
      .tx_done     (tx_done),
      .rx_dv       (rx_dv),
      .rx_byte     (rx_byte),
      .link_busy   (link_busy),
      .link_ok     (link_ok)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_total++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   // Reference model state.
   int   rr_ptr_m  = 0;
   logic link_ok_m = 1'b0;

   // UART TX stand-in bookkeeping.
   logic [7:0] tx_log[$];
   int         tx_done_cnt = 0;
   int         tx_stall_at = -1;

   // UART TX stand-in: acts just after each rising edge. It logs the byte
   // offered with tx_start, waits 1..4 cycles, checks the byte stayed stable
   // and pulses tx_done. With tx_stall_at set it withholds that tx_done
   // until reset.
   initial begin : tx_model
      logic [7:0] b;
      int         d;
      forever begin
         @(posedge clk); #1;
         while (tx_start === 1'b1 && pll_rst === 1'b0) begin
            b = tx_byte;
            tx_log.push_back(b);
            if (tx_done_cnt == tx_stall_at) begin
               wait (pll_rst === 1'b1);
            end else begin
               d = $urandom_range(1, 4);
               repeat (d) begin @(posedge clk); #1; end
               check("tx_byte_stable", {24'h0, tx_byte}, {24'h0, b});
               tx_done = 1'b1;
               tx_done_cnt++;
               @(posedge clk); #1;
               tx_done = 1'b0;
            end
         end
      end
   end

   function automatic int pick_model(input logic [NREQ-1:0] r);
      for (int k = 0; k < NREQ; k++) begin
         if (r[(rr_ptr_m + k) % NREQ]) return (rr_ptr_m + k) % NREQ;
      end
      return -1;
   endfunction

   // One complete transaction, entered on a falling edge while the DUT is
   // idle with req already set. req_mode: 0 drop own req at done, 1 keep
   // all, 2 clear all. rx bytes come from rx_word, MSB first.
   task automatic do_txn(input int n_rx, input logic [31:0] rx_word, input bit stray,
                         input bit drop_early, input int req_mode);
      int          w;
      int          cyc;
      int          gap_n;
      logic [31:0] cmd;
      logic        exp_m;
      logic [31:0] resp_m;
      logic        err_m;
      w = pick_model(req);
      if (w < 0) w = 0;
      cmd      = cmd_word[32*w +: 32];
      exp_m    = expect_resp[w];
      rr_ptr_m = (w + 1) % NREQ;
      tx_log.delete();
      tx_done_cnt = 0;

      @(negedge clk);
      check("grant", {28'h0, grant}, 32'(1 << w));
      if (drop_early) req[w] = 1'b0;

      cyc = 0;
      while (tx_done_cnt < 4 && cyc < 500) begin @(negedge clk); cyc++; end
      check("tx_nbytes", 32'(tx_log.size()), 32'd4);
      for (int i = 0; i < 4 && i < tx_log.size(); i++)
         check("tx_wire_byte", {24'h0, tx_log[i]}, {24'h0, cmd[31-8*i -: 8]});

      @(negedge clk);
      resp_m = '0;
      err_m  = 1'b0;
      if (exp_m) begin
         for (int i = 0; i < n_rx; i++) begin
            repeat ($urandom_range(0, 10)) @(negedge clk);
            rx_byte = rx_word[31-8*i -: 8];
            rx_dv   = 1'b1;
            @(negedge clk);
            rx_dv   = 1'b0;
         end
         if (n_rx >= 4) begin
            resp_m    = rx_word;
            link_ok_m = 1'b1;
         end else begin
            err_m     = 1'b1;
            link_ok_m = 1'b0;
         end
      end

      cyc = 0;
      while (done == '0 && cyc < 300) begin @(negedge clk); cyc++; end
      if (exp_m && n_rx == 0) check("timeout_latency", 32'(cyc), 32'(TO));
      check("done", {28'h0, done}, 32'(1 << w));
      check("resp_word", resp_word, resp_m);
      check("resp_err", {31'h0, resp_err}, {31'h0, err_m});
      check("link_ok", {31'h0, link_ok}, {31'h0, link_ok_m});
      if (req_mode == 0)      req[w] = 1'b0;
      else if (req_mode == 2) req    = '0;

      @(negedge clk);
      check("done_pulse", {28'h0, done}, 32'h0);
      check("grant_drop", {28'h0, grant}, 32'h0);
      gap_n = 0;
      while (link_busy && gap_n < 100) begin
         gap_n++;
         if (stray && gap_n == 3) begin
            rx_byte = 8'($urandom);
            rx_dv   = 1'b1;
         end else begin
            rx_dv = 1'b0;
         end
         @(negedge clk);
      end
      rx_dv = 1'b0;
      check("gap_cycles", 32'(gap_n), 32'(GAP));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_grant"},     {28'h0, grant},     32'h0);
      check({tag, "_done"},      {28'h0, done},      32'h0);
      check({tag, "_resp_word"}, resp_word,          32'h0);
      check({tag, "_resp_err"},  {31'h0, resp_err},  32'h0);
      check({tag, "_tx_start"},  {31'h0, tx_start},  32'h0);
      check({tag, "_tx_byte"},   {24'h0, tx_byte},   32'h0);
      check({tag, "_link_busy"}, {31'h0, link_busy}, 32'h0);
      check({tag, "_link_ok"},   {31'h0, link_ok},   32'h0);
   endtask

   task automatic new_cmd(input int i, input logic e);
      cmd_word[32*i +: 32] = $urandom | 32'h0101_0101;
      expect_resp[i]       = e;
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int          cyc;
      int          n_rx;
      logic [31:0] w32;

      repeat (3) @(negedge clk);
      check_all_zero("reset");
      pll_rst = 1'b0;
      @(negedge clk);

      // All four held, no replies: grants rotate 0,1,2,3,0.
      for (int i = 0; i < NREQ; i++) new_cmd(i, 1'b0);
      req = 4'b1111;
      for (int t = 0; t < 5; t++) do_txn(0, 32'h0, 1'b0, 1'b0, (t == 4) ? 2 : 1);

      // Command without reply.
      cmd_word[31:0] = 32'hA5C3_0F12;
      expect_resp[0] = 1'b0;
      req = 4'b0001;
      do_txn(0, 32'h0, 1'b0, 1'b0, 0);

      // Command with a 4-byte reply.
      cmd_word[63:32] = 32'h0400_0001;
      expect_resp[1]  = 1'b1;
      req = 4'b0010;
      do_txn(4, 32'h1234_5678, 1'b0, 1'b0, 0);

      // Reply never arrives: timeout after TO cycles.
      new_cmd(2, 1'b1);
      req = 4'b0100;
      do_txn(0, 32'h0, 1'b0, 1'b0, 0);

      // Two bytes then silence, stray byte during the guard gap.
      new_cmd(3, 1'b1);
      req = 4'b1000;
      do_txn(2, 32'hDEAD_BEEF, 1'b1, 1'b0, 0);

      // Clean reply afterwards must not contain the stray byte.
      new_cmd(0, 1'b1);
      req = 4'b0001;
      do_txn(4, 32'hCAFE_F00D, 1'b0, 1'b0, 0);

      // Randomised traffic.
      for (int t = 0; t < 24; t++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!req[i] && $urandom_range(0, 1) == 1) begin
               new_cmd(i, 1'($urandom_range(0, 1)));
               req[i] = 1'b1;
            end
         end
         if (req == '0) begin
            new_cmd(t % NREQ, 1'b1);
            req[t % NREQ] = 1'b1;
         end
         case ($urandom_range(0, 5))
            0:       n_rx = 0;
            1:       n_rx = 2;
            default: n_rx = 4;
         endcase
         w32 = $urandom;
         do_txn(n_rx, w32, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 0);
      end

      // Known-good reply so link_ok and resp_word are nonzero before reset.
      req = '0;
      new_cmd(1, 1'b1);
      req = 4'b0010;
      do_txn(4, 32'h8765_4321, 1'b0, 1'b0, 0);

      // Reset while the third byte waits for tx_done.
      req = '0;
      cmd_word[31:0] = 32'h1122_3344;
      expect_resp[0] = 1'b0;
      tx_log.delete();
      tx_done_cnt = 0;
      tx_stall_at = 2;
      req = 4'b0001;
      cyc = 0;
      while (tx_log.size() < 3 && cyc < 500) begin @(negedge clk); cyc++; end
      check("stall_reached", 32'(tx_log.size()), 32'd3);
      check("stall_busy", {31'h0, link_busy}, 32'h1);
      pll_rst = 1'b1;
      @(negedge clk);
      check_all_zero("midrst");
      tx_stall_at = -1;
      rr_ptr_m    = 0;
      link_ok_m   = 1'b0;
      pll_rst     = 1'b0;
      // Fresh transaction restarts from byte 0.
      do_txn(0, 32'h0, 1'b0, 1'b0, 0);

      repeat (4) @(negedge clk);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule : tb_laser_link_scheduler
